dragon_mover: RTL and testbench

- Consumes the dragon target position from the dragon behaviour controller and walks the dragon one tile at a time toward it.
- Produces dragon_pos, dragon_state and the arrival pulses that the behaviour controller needs to switch targets.
- Runs off the per-frame trigger tick and sits between the target controller and the sprite/collision logic.

---
 rtl/dragon_mover_if.sv | 23 ++
 rtl/dragon_mover.sv | 137 +++++++++++++
 tb/tb_dragon_mover.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dragon_mover_if.sv
// Bundles the dragon mover's frame, target and status signals between
// the behaviour controller, collision logic and the mover itself.
interface dragon_mover_if;
  logic       trigger;
  logic       dragon_hurt;
  logic [7:0] target_pos;
  logic [7:0] player_pos;
  logic [7:0] sheep_pos;
  logic [7:0] dragon_pos;
  logic [6:0] dragon_state;
  logic       target_reached_player;
  logic       target_reached_sheep;

  modport master (
    output trigger, dragon_hurt, target_pos, player_pos, sheep_pos,
    input  dragon_pos, dragon_state, target_reached_player, target_reached_sheep
  );

  modport slave (
    input  trigger, dragon_hurt, target_pos, player_pos, sheep_pos,
    output dragon_pos, dragon_state, target_reached_player, target_reached_sheep
  );
endinterface

// File: rtl/dragon_mover.sv
// Walks the dragon one tile per MOVE_PERIOD frame ticks toward its target,
// freezing for STUN_FRAMES ticks after a hit and pulsing on arrival.
module dragon_mover #(
  parameter int unsigned MOVE_PERIOD = 2,
  parameter int unsigned STUN_FRAMES = 8,
  parameter logic [7:0]  START_POS   = 8'h00
) (
  input logic           clk,
  input logic           reset,
  dragon_mover_if.slave bus
);
  localparam logic [3:0] MP = 4'(MOVE_PERIOD);
  localparam logic [3:0] SF = 4'(STUN_FRAMES);

  typedef enum logic [1:0] {WAIT, STEP, STUN} state_t;

  state_t     state, state_next;
  logic [3:0] tick_cnt, tick_next;
  logic [3:0] stun_cnt, stun_next;
  logic [7:0] pos, pos_next;
  logic [2:0] growth, growth_next;
  logic [1:0] dir, dir_next;
  logic       moving, moving_next;
  logic       step_done, step_done_next;
  logic       hit_player, hit_player_next;
  logic       hit_sheep, hit_sheep_next;

  logic [3:0] x, y, tx, ty;
  logic [4:0] dx, dy, adx, ady;
  logic       go_x, go_y;

  // Signed 5-bit deltas; the larger-magnitude axis moves, ties favour x.
  always_comb begin
    x    = pos[7:4];
    y    = pos[3:0];
    tx   = bus.target_pos[7:4];
    ty   = bus.target_pos[3:0];
    dx   = {1'b0, tx} - {1'b0, x};
    dy   = {1'b0, ty} - {1'b0, y};
    adx  = dx[4] ? 5'(5'd0 - dx) : dx;
    ady  = dy[4] ? 5'(5'd0 - dy) : dy;
    go_x = (dx != 5'd0) && (adx >= ady);
    go_y = (dy != 5'd0);
  end

  always_comb begin
    state_next      = state;
    tick_next       = tick_cnt;
    stun_next       = stun_cnt;
    pos_next        = pos;
    growth_next     = growth;
    dir_next        = dir;
    moving_next     = moving;
    step_done_next  = 1'b0;
    // Arrival is judged on the registered post-step position, one edge after the move.
    hit_player_next = step_done && !bus.dragon_hurt && (pos == bus.player_pos);
    hit_sheep_next  = step_done && !bus.dragon_hurt && (pos == bus.sheep_pos);

    if (bus.dragon_hurt) begin
      state_next  = STUN;
      stun_next   = '0;
      moving_next = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (bus.trigger) begin
            if (tick_cnt + 4'd1 == MP) begin
              tick_next  = '0;
              state_next = STEP;
            end else begin
              tick_next = tick_cnt + 4'd1;
            end
          end
        end
        STEP: begin
          state_next     = WAIT;
          step_done_next = 1'b1;
          growth_next    = (growth == 3'd7) ? growth : growth + 3'd1;
          if (go_x) begin
            pos_next[7:4] = dx[4] ? x - 4'd1 : x + 4'd1;
            dir_next      = dx[4] ? 2'b11 : 2'b01;
            moving_next   = 1'b1;
          end else if (go_y) begin
            pos_next[3:0] = dy[4] ? y - 4'd1 : y + 4'd1;
            dir_next      = dy[4] ? 2'b00 : 2'b10;
            moving_next   = 1'b1;
          end else begin
            moving_next = 1'b0;
          end
        end
        STUN: begin
          if (bus.trigger) begin
            if (stun_cnt + 4'd1 == SF) begin
              state_next = WAIT;
              tick_next  = '0;
              stun_next  = '0;
            end else begin
              stun_next = stun_cnt + 4'd1;
            end
          end
        end
        default: state_next = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT;
      tick_cnt   <= '0;
      stun_cnt   <= '0;
      pos        <= START_POS;
      growth     <= '0;
      dir        <= '0;
      moving     <= 1'b0;
      step_done  <= 1'b0;
      hit_player <= 1'b0;
      hit_sheep  <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_next;
      stun_cnt   <= stun_next;
      pos        <= pos_next;
      growth     <= growth_next;
      dir        <= dir_next;
      moving     <= moving_next;
      step_done  <= step_done_next;
      hit_player <= hit_player_next;
      hit_sheep  <= hit_sheep_next;
    end
  end

  assign bus.dragon_pos            = pos;
  assign bus.dragon_state          = {state == STUN, moving, dir, growth};
  assign bus.target_reached_player = hit_player;
  assign bus.target_reached_sheep  = hit_sheep;
endmodule

// File: tb/tb_dragon_mover.sv
// Self-checking bench for dragon_mover: hand-derived vector table, directed
// corner sequences, then random stimulus against a behavioural model.
module tb_dragon_mover;
  localparam int MP = 2;
  localparam int SF = 4;

  logic clk;
  logic reset;
  dragon_mover_if bus();

  dragon_mover #(.MOVE_PERIOD(MP), .STUN_FRAMES(SF), .START_POS(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: positions as ints, countdowns of remaining ticks.
  int mx, my, mgrow, mdir, mticks_left, mstun_left;
  bit mmov, mstun, mstep_pend, mpulse_chk, mpl, msh;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_edge(input bit r, input bit t, input bit h,
                            input logic [7:0] tgt, input logic [7:0] pl, input logic [7:0] sh);
    int dx, dy;
    logic [7:0] here;
    if (r) begin
      mx = 0; my = 0; mgrow = 0; mdir = 0; mmov = 0; mstun = 0;
      mticks_left = MP; mstun_left = 0; mstep_pend = 0; mpulse_chk = 0; mpl = 0; msh = 0;
      return;
    end
    here = 8'(mx * 16 + my);
    mpl = mpulse_chk && !h && (here == pl);
    msh = mpulse_chk && !h && (here == sh);
    mpulse_chk = 0;
    if (h) begin
      mstun = 1; mstun_left = SF; mmov = 0; mstep_pend = 0;
    end else if (mstep_pend) begin
      dx = int'(tgt[7:4]) - mx;
      dy = int'(tgt[3:0]) - my;
      mgrow = (mgrow < 7) ? mgrow + 1 : 7;
      if (dx != 0 && iabs(dx) >= iabs(dy)) begin
        mx += sgn(dx); mdir = (dx > 0) ? 1 : 3; mmov = 1;
      end else if (dy != 0) begin
        my += sgn(dy); mdir = (dy > 0) ? 2 : 0; mmov = 1;
      end else begin
        mmov = 0;
      end
      mstep_pend = 0; mpulse_chk = 1; mticks_left = MP;
    end else if (mstun) begin
      if (t) begin
        mstun_left--;
        if (mstun_left == 0) begin
          mstun = 0; mticks_left = MP;
        end
      end
    end else if (t) begin
      mticks_left--;
      if (mticks_left == 0) begin
        mstep_pend = 1; mticks_left = MP;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit h);
    reset           = r;
    bus.trigger     = t;
    bus.dragon_hurt = h;
    model_edge(r, t, h, bus.target_pos, bus.player_pos, bus.sheep_pos);
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input bit r, input bit t);
    cyc(r, t, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       trig;
    logic [7:0] target;
    logic [7:0] exp_pos;
    logic [6:0] exp_state;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit prev_trig, t, h, r;
    reset = 1'b1;
    bus.trigger = 1'b0; bus.dragon_hurt = 1'b0;
    bus.target_pos = 8'h32; bus.player_pos = 8'hFF; bus.sheep_pos = 8'hFF;

    // Diagonal chase toward 8'h32; each row is a trigger cycle then an idle cycle.
    tbl[0]  = '{1'b1, 1'b0, 8'h32, 8'h00, 7'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h32, 8'h00, 7'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h32, 8'h10, 7'h29};
    tbl[3]  = '{1'b0, 1'b1, 8'h32, 8'h10, 7'h29};
    tbl[4]  = '{1'b0, 1'b1, 8'h32, 8'h20, 7'h2A};
    tbl[5]  = '{1'b0, 1'b1, 8'h32, 8'h20, 7'h2A};
    tbl[6]  = '{1'b0, 1'b1, 8'h32, 8'h21, 7'h33};
    tbl[7]  = '{1'b0, 1'b1, 8'h32, 8'h21, 7'h33};
    tbl[8]  = '{1'b0, 1'b1, 8'h32, 8'h31, 7'h2C};
    tbl[9]  = '{1'b0, 1'b1, 8'h32, 8'h31, 7'h2C};
    tbl[10] = '{1'b0, 1'b1, 8'h32, 8'h32, 7'h35};
    tbl[11] = '{1'b0, 1'b1, 8'h32, 8'h32, 7'h35};
    tbl[12] = '{1'b0, 1'b1, 8'h32, 8'h32, 7'h16};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      bus.target_pos = tbl[i].target;
      pair(tbl[i].rst, tbl[i].trig);
      chk($sformatf("tbl%0d_pos", i), 32'(bus.dragon_pos), 32'(tbl[i].exp_pos));
      chk($sformatf("tbl%0d_state", i), 32'(bus.dragon_state), 32'(tbl[i].exp_state));
      chk($sformatf("tbl%0d_pulses", i),
          32'({bus.target_reached_player, bus.target_reached_sheep}), 32'(0));
    end

    // Arrival pulses on a shared player/sheep tile.
    bus.target_pos = 8'h01; bus.player_pos = 8'h01; bus.sheep_pos = 8'h01;
    cyc(1, 0, 0);
    chk("rst_pos", 32'(bus.dragon_pos), 32'h00);
    chk("rst_state", 32'(bus.dragon_state), 32'h00);
    pair(0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("arr_pos", 32'(bus.dragon_pos), 32'h01);
    chk("arr_state", 32'(bus.dragon_state), 32'h31);
    chk("arr_early", 32'({bus.target_reached_player, bus.target_reached_sheep}), 32'b00);
    cyc(0, 0, 0);
    chk("arr_pulse", 32'({bus.target_reached_player, bus.target_reached_sheep}), 32'b11);
    cyc(0, 0, 0);
    chk("arr_pulse_end", 32'({bus.target_reached_player, bus.target_reached_sheep}), 32'b00);

    // Stun from WAIT, extended by a second hit after two ticks.
    bus.target_pos = 8'h32; bus.player_pos = 8'hFF; bus.sheep_pos = 8'hFF;
    cyc(1, 0, 0);
    pair(0, 1);
    cyc(0, 0, 1);
    chk("stun_enter", 32'(bus.dragon_state), 32'h40);
    pair(0, 1); pair(0, 1);
    chk("stun_2tick", 32'(bus.dragon_state), 32'h40);
    cyc(0, 0, 1);
    pair(0, 1); pair(0, 1); pair(0, 1);
    chk("stun_5tick_state", 32'(bus.dragon_state), 32'h40);
    chk("stun_5tick_pos", 32'(bus.dragon_pos), 32'h00);
    pair(0, 1);
    chk("stun_exit", 32'(bus.dragon_state), 32'h00);
    pair(0, 1);
    chk("post_stun_wait", 32'(bus.dragon_pos), 32'h00);
    pair(0, 1);
    chk("post_stun_step_pos", 32'(bus.dragon_pos), 32'h10);
    chk("post_stun_step_state", 32'(bus.dragon_state), 32'h29);

    // Reset while stunned.
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("rst_stun_pos", 32'(bus.dragon_pos), 32'h00);
    chk("rst_stun_state", 32'(bus.dragon_state), 32'h00);

    // Hit landing in the STEP cycle.
    bus.player_pos = 8'h10; bus.sheep_pos = 8'h10;
    pair(0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("hurt_step_pos", 32'(bus.dragon_pos), 32'h00);
    chk("hurt_step_state", 32'(bus.dragon_state), 32'h40);
    cyc(0, 0, 0);
    chk("hurt_step_pulse", 32'({bus.target_reached_player, bus.target_reached_sheep}), 32'b00);

    // Growth saturation and x clamping at the right edge.
    bus.target_pos = 8'hF0; bus.player_pos = 8'hFF; bus.sheep_pos = 8'hFF;
    cyc(1, 0, 0);
    for (int s = 0; s < 9; s++) begin
      pair(0, 1); pair(0, 1);
    end
    chk("sat9_state", 32'(bus.dragon_state), 32'h2F);
    chk("sat9_pos", 32'(bus.dragon_pos), 32'h90);
    for (int s = 0; s < 8; s++) begin
      pair(0, 1); pair(0, 1);
    end
    chk("sat17_pos", 32'(bus.dragon_pos), 32'hF0);
    chk("sat17_state", 32'(bus.dragon_state), 32'h0F);

    // Random traffic against the model.
    cyc(1, 0, 0);
    prev_trig = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0)
        bus.target_pos = {4'($urandom_range(15)), 4'($urandom_range(12))};
      bus.player_pos = ($urandom_range(2) == 0) ? bus.target_pos
                       : {4'($urandom_range(15)), 4'($urandom_range(12))};
      bus.sheep_pos  = ($urandom_range(2) == 0) ? 8'(mx * 16 + my)
                       : {4'($urandom_range(15)), 4'($urandom_range(12))};
      t = !prev_trig && ($urandom_range(2) != 0);
      h = ($urandom_range(40) == 0);
      r = ($urandom_range(150) == 0);
      prev_trig = t;
      cyc(r, t, h);
      chk("rnd_pos", 32'(bus.dragon_pos), 32'(mx * 16 + my));
      chk("rnd_state", 32'(bus.dragon_state),
          32'({mstun, mmov, 2'(mdir), 3'(mgrow)}));
      chk("rnd_player", 32'(bus.target_reached_player), 32'(mpl));
      chk("rnd_sheep", 32'(bus.target_reached_sheep), 32'(msh));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
